// File: rtl/note_draw_ctrl_pkg.sv
// Shared definitions for the note label renderer: FSM states, note codes,
// and the 12x12 glyph bitmaps. Each glyph is twelve 12-bit rows, top row in
// the most significant bits and the leftmost column in each row's MSB.
package note_draw_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHARP  = 3'd2,
    LETTER = 3'd3,
    OCT    = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [3:0] NOTE_A  = 4'd1;
  localparam logic [3:0] NOTE_AS = 4'd2;
  localparam logic [3:0] NOTE_B  = 4'd3;
  localparam logic [3:0] NOTE_C  = 4'd4;
  localparam logic [3:0] NOTE_CS = 4'd5;
  localparam logic [3:0] NOTE_D  = 4'd6;
  localparam logic [3:0] NOTE_DS = 4'd7;
  localparam logic [3:0] NOTE_E  = 4'd8;
  localparam logic [3:0] NOTE_F  = 4'd9;
  localparam logic [3:0] NOTE_FS = 4'd10;
  localparam logic [3:0] NOTE_G  = 4'd11;
  localparam logic [3:0] NOTE_GS = 4'd12;

  localparam logic [143:0] GLYPH_BLANK = 144'd0;

  localparam logic [143:0] GLYPH_SHARP = {12'h000, 12'h120, 12'h120, 12'h7F8, 12'h120, 12'h120,
                                          12'h7F8, 12'h120, 12'h120, 12'h000, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_A = {12'h000, 12'h0F0, 12'h198, 12'h30C, 12'h30C, 12'h3FC,
                                      12'h30C, 12'h30C, 12'h30C, 12'h30C, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_B = {12'h000, 12'h3F0, 12'h318, 12'h318, 12'h3F0, 12'h318,
                                      12'h30C, 12'h30C, 12'h318, 12'h3F0, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_C = {12'h000, 12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h300,
                                      12'h300, 12'h300, 12'h18C, 12'h0F8, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_D = {12'h000, 12'h3E0, 12'h330, 12'h318, 12'h30C, 12'h30C,
                                      12'h30C, 12'h318, 12'h330, 12'h3E0, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_E = {12'h000, 12'h3FC, 12'h300, 12'h300, 12'h3F0, 12'h300,
                                      12'h300, 12'h300, 12'h300, 12'h3FC, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_F = {12'h000, 12'h3FC, 12'h300, 12'h300, 12'h3F0, 12'h300,
                                      12'h300, 12'h300, 12'h300, 12'h300, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_G = {12'h000, 12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h33C,
                                      12'h30C, 12'h30C, 12'h18C, 12'h0F8, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_1 = {12'h000, 12'h060, 12'h0E0, 12'h060, 12'h060, 12'h060,
                                      12'h060, 12'h060, 12'h060, 12'h1F8, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_2 = {12'h000, 12'h1F0, 12'h318, 12'h018, 12'h030, 12'h060,
                                      12'h0C0, 12'h180, 12'h300, 12'h3F8, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_3 = {12'h000, 12'h1F0, 12'h318, 12'h018, 12'h0F0, 12'h018,
                                      12'h018, 12'h018, 12'h318, 12'h1F0, 12'h000, 12'h000};
  localparam logic [143:0] GLYPH_4 = {12'h000, 12'h030, 12'h070, 12'h0F0, 12'h1B0, 12'h330,
                                      12'h3F8, 12'h030, 12'h030, 12'h030, 12'h000, 12'h000};

  // Bit (row, col) of a glyph; row 0 / col 0 is the top-left pixel (bit 143).
  function automatic logic glyph_bit(input logic [143:0] g, input logic [3:0] row,
                                     input logic [3:0] col);
    logic [7:0] idx;
    idx = 8'(row) * 8'd12 + 8'(col);
    return g[8'd143 - idx];
  endfunction

endpackage

// File: rtl/note_draw_ctrl_if.sv
// Request and pixel-port bundle between the note decode logic, the label
// renderer and the VGA adapter. "master" issues requests and watches the
// pixel stream; "slave" is the renderer.
interface note_draw_ctrl_if;
  logic       draw_req;
  logic       clear_req;
  logic [3:0] note;
  logic [1:0] octave;
  logic [7:0] x;
  logic [6:0] y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       writeEn;
  logic       busy;
  logic       done;

  modport master (
    output draw_req, clear_req, note, octave, x, y,
    input  x_out, y_out, colour, writeEn, busy, done
  );

  modport slave (
    input  draw_req, clear_req, note, octave, x, y,
    output x_out, y_out, colour, writeEn, busy, done
  );
endinterface

// File: rtl/note_draw_ctrl_glyph_rom.sv
// Combinational glyph lookup: picks the letter, sharp and octave-digit
// bitmaps for a note code and octave. Unknown note codes give blank cells.
module note_glyph_rom
  import note_draw_ctrl_pkg::*;
(
  input  logic [3:0]   note_i,
  input  logic [1:0]   octave_i,
  output logic [143:0] letter_o,
  output logic [143:0] sharp_o,
  output logic [143:0] octave_o
);

  // Letter and sharp selection from the note code
  always_comb begin
    letter_o = GLYPH_BLANK;
    sharp_o  = GLYPH_BLANK;
    case (note_i)
      NOTE_A:  letter_o = GLYPH_A;
      NOTE_AS: begin letter_o = GLYPH_A; sharp_o = GLYPH_SHARP; end
      NOTE_B:  letter_o = GLYPH_B;
      NOTE_C:  letter_o = GLYPH_C;
      NOTE_CS: begin letter_o = GLYPH_C; sharp_o = GLYPH_SHARP; end
      NOTE_D:  letter_o = GLYPH_D;
      NOTE_DS: begin letter_o = GLYPH_D; sharp_o = GLYPH_SHARP; end
      NOTE_E:  letter_o = GLYPH_E;
      NOTE_F:  letter_o = GLYPH_F;
      NOTE_FS: begin letter_o = GLYPH_F; sharp_o = GLYPH_SHARP; end
      NOTE_G:  letter_o = GLYPH_G;
      NOTE_GS: begin letter_o = GLYPH_G; sharp_o = GLYPH_SHARP; end
      default: ;
    endcase
  end

  // Octave 0..3 is shown as digit 1..4
  always_comb begin
    case (octave_i)
      2'd0:    octave_o = GLYPH_1;
      2'd1:    octave_o = GLYPH_2;
      2'd2:    octave_o = GLYPH_3;
      default: octave_o = GLYPH_4;
    endcase
  end

endmodule

// File: rtl/note_draw_ctrl.sv
// Note label renderer: writes sharp, letter and octave glyph cells into the
// VGA pixel port, one pixel per clock, with a one-deep pending request slot.
// Define NOTE_DRAW_CLEAR_EN to build the full-screen clear sweep; without it
// clear_req is ignored and draw behaviour is unchanged.
module note_draw_ctrl
  import note_draw_ctrl_pkg::*;
#(
  parameter int unsigned GLYPH_W   = 12,
  parameter int unsigned GLYPH_H   = 12,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  FG_COLOUR = 3'b100,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input logic              clk,
  input logic              resetn,
  note_draw_ctrl_if.slave  bus
);

  localparam logic [7:0] GLY_COL_LAST = 8'(GLYPH_W - 1);
  localparam logic [6:0] GLY_ROW_LAST = 7'(GLYPH_H - 1);

  state_t     state_q, state_d;
  logic [6:0] row_q, row_d;
  logic [7:0] col_q, col_d;
  logic [3:0] note_q, note_d;
  logic [1:0] oct_q, oct_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       pd_draw_q, pd_draw_d;
  logic [3:0] pd_note_q, pd_note_d;
  logic [1:0] pd_oct_q, pd_oct_d;
  logic [7:0] pd_x_q, pd_x_d;
  logic [6:0] pd_y_q, pd_y_d;
  logic       pd_clear_q, pd_clear_d;
  logic [7:0] x_out_q, x_out_d;
  logic [6:0] y_out_q, y_out_d;
  logic [2:0] colour_q, colour_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic         clr_req;
  logic [143:0] letter_g, sharp_g, octave_g;
  logic [143:0] glyph;
  logic [1:0]   phase;

`ifdef NOTE_DRAW_CLEAR_EN
  localparam logic [7:0] CLR_COL_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] CLR_ROW_LAST = 7'(SCREEN_H - 1);
  assign clr_req = bus.clear_req;
`else
  logic unused_clear_req;
  assign unused_clear_req = bus.clear_req;
  assign clr_req          = 1'b0;
`endif

  note_glyph_rom u_rom (
    .note_i   (note_d),
    .octave_i (oct_d),
    .letter_o (letter_g),
    .sharp_o  (sharp_g),
    .octave_o (octave_g)
  );

  // Next-state: capture requests into the pending slot, launch from it when
  // idle or finishing, otherwise step the raster scan.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    note_d     = note_q;
    oct_d      = oct_q;
    x_d        = x_q;
    y_d        = y_q;
    pd_draw_d  = pd_draw_q;
    pd_note_d  = pd_note_q;
    pd_oct_d   = pd_oct_q;
    pd_x_d     = pd_x_q;
    pd_y_d     = pd_y_q;
    pd_clear_d = pd_clear_q;

    // A clear discards older draws, but a draw arriving with it survives.
    if (clr_req) begin
      pd_clear_d = 1'b1;
      pd_draw_d  = 1'b0;
    end
    if (bus.draw_req) begin
      pd_draw_d = 1'b1;
      pd_note_d = bus.note;
      pd_oct_d  = bus.octave;
      pd_x_d    = bus.x;
      pd_y_d    = bus.y;
    end

    case (state_q)
      IDLE, FINISH: begin
        row_d = 7'd0;
        col_d = 8'd0;
        if (pd_clear_d) begin
          state_d    = CLEAR;
          pd_clear_d = 1'b0;
        end else if (pd_draw_d) begin
          state_d   = SHARP;
          pd_draw_d = 1'b0;
          note_d    = pd_note_d;
          oct_d     = pd_oct_d;
          x_d       = pd_x_d;
          y_d       = pd_y_d;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef NOTE_DRAW_CLEAR_EN
      CLEAR: begin
        if (col_q == CLR_COL_LAST) begin
          col_d = 8'd0;
          if (row_q == CLR_ROW_LAST) begin
            row_d   = 7'd0;
            state_d = FINISH;
          end else begin
            row_d = row_q + 7'd1;
          end
        end else begin
          col_d = col_q + 8'd1;
        end
      end
`endif
      SHARP, LETTER, OCT: begin
        if (col_q == GLY_COL_LAST) begin
          col_d = 8'd0;
          if (row_q == GLY_ROW_LAST) begin
            row_d = 7'd0;
            if (state_q == SHARP)       state_d = LETTER;
            else if (state_q == LETTER) state_d = OCT;
            else                        state_d = FINISH;
          end else begin
            row_d = row_q + 7'd1;
          end
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel for the coming cycle, derived from the next scan position so the
  // first pixel is registered on the same edge that accepts the request.
  always_comb begin
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    colour_d = BG_COLOUR;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    glyph    = GLYPH_BLANK;
    phase    = 2'd0;
    case (state_d)
      SHARP:  begin glyph = sharp_g;  phase = 2'd0; end
      LETTER: begin glyph = letter_g; phase = 2'd1; end
      OCT:    begin glyph = octave_g; phase = 2'd2; end
      default: ;
    endcase
    if (state_d inside {SHARP, LETTER, OCT}) begin
      busy_d   = 1'b1;
      x_out_d  = 8'(32'(x_d) + 32'(phase) * GLYPH_W + 32'(col_d));
      y_out_d  = 7'(32'(y_d) + 32'(row_d));
      colour_d = glyph_bit(glyph, row_d[3:0], col_d[3:0]) ? FG_COLOUR : BG_COLOUR;
      we_d     = (32'(x_out_d) < SCREEN_W) && (32'(y_out_d) < SCREEN_H);
`ifdef NOTE_DRAW_CLEAR_EN
    end else if (state_d == CLEAR) begin
      busy_d   = 1'b1;
      x_out_d  = col_d;
      y_out_d  = row_d;
      colour_d = BG_COLOUR;
      we_d     = (32'(x_out_d) < SCREEN_W) && (32'(y_out_d) < SCREEN_H);
`endif
    end else if (state_d == FINISH) begin
      busy_d = 1'b1;
      done_d = 1'b1;
    end
  end

  // State, scan counters, latched label, pending slot and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      row_q      <= 7'd0;
      col_q      <= 8'd0;
      note_q     <= 4'd0;
      oct_q      <= 2'd0;
      x_q        <= 8'd0;
      y_q        <= 7'd0;
      pd_draw_q  <= 1'b0;
      pd_note_q  <= 4'd0;
      pd_oct_q   <= 2'd0;
      pd_x_q     <= 8'd0;
      pd_y_q     <= 7'd0;
      pd_clear_q <= 1'b0;
      x_out_q    <= 8'd0;
      y_out_q    <= 7'd0;
      colour_q   <= BG_COLOUR;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      note_q     <= note_d;
      oct_q      <= oct_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pd_draw_q  <= pd_draw_d;
      pd_note_q  <= pd_note_d;
      pd_oct_q   <= pd_oct_d;
      pd_x_q     <= pd_x_d;
      pd_y_q     <= pd_y_d;
      pd_clear_q <= pd_clear_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      colour_q   <= colour_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.x_out   = x_out_q;
  assign bus.y_out   = y_out_q;
  assign bus.colour  = colour_q;
  assign bus.writeEn = we_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_note_draw_ctrl.sv
// Directed bench for note_draw_ctrl: label drawing, blank sharp cells,
// clipping, clear-with-queued-draw, pending overwrite and mid-draw reset.
module tb_note_draw_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  note_draw_ctrl_if ifc ();

  note_draw_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  // Glyph rows: 0 blank, 1 sharp, 2..8 A..G, 9..12 digits 1..4
  localparam logic [11:0] GROWS [13][12] = '{
    '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000},
    '{12'h000, 12'h120, 12'h120, 12'h7F8, 12'h120, 12'h120, 12'h7F8, 12'h120, 12'h120, 12'h000, 12'h000, 12'h000},
    '{12'h000, 12'h0F0, 12'h198, 12'h30C, 12'h30C, 12'h3FC, 12'h30C, 12'h30C, 12'h30C, 12'h30C, 12'h000, 12'h000},
    '{12'h000, 12'h3F0, 12'h318, 12'h318, 12'h3F0, 12'h318, 12'h30C, 12'h30C, 12'h318, 12'h3F0, 12'h000, 12'h000},
    '{12'h000, 12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h300, 12'h300, 12'h300, 12'h18C, 12'h0F8, 12'h000, 12'h000},
    '{12'h000, 12'h3E0, 12'h330, 12'h318, 12'h30C, 12'h30C, 12'h30C, 12'h318, 12'h330, 12'h3E0, 12'h000, 12'h000},
    '{12'h000, 12'h3FC, 12'h300, 12'h300, 12'h3F0, 12'h300, 12'h300, 12'h300, 12'h300, 12'h3FC, 12'h000, 12'h000},
    '{12'h000, 12'h3FC, 12'h300, 12'h300, 12'h3F0, 12'h300, 12'h300, 12'h300, 12'h300, 12'h300, 12'h000, 12'h000},
    '{12'h000, 12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h33C, 12'h30C, 12'h30C, 12'h18C, 12'h0F8, 12'h000, 12'h000},
    '{12'h000, 12'h060, 12'h0E0, 12'h060, 12'h060, 12'h060, 12'h060, 12'h060, 12'h060, 12'h1F8, 12'h000, 12'h000},
    '{12'h000, 12'h1F0, 12'h318, 12'h018, 12'h030, 12'h060, 12'h0C0, 12'h180, 12'h300, 12'h3F8, 12'h000, 12'h000},
    '{12'h000, 12'h1F0, 12'h318, 12'h018, 12'h0F0, 12'h018, 12'h018, 12'h018, 12'h318, 12'h1F0, 12'h000, 12'h000},
    '{12'h000, 12'h030, 12'h070, 12'h0F0, 12'h1B0, 12'h330, 12'h3F8, 12'h030, 12'h030, 12'h030, 12'h000, 12'h000}
  };

  // Requests injected during a scan: pixel index (-1 = none) and payload
  int         inj_at   [2];
  logic [3:0] inj_note [2];
  logic [1:0] inj_oct  [2];
  logic [7:0] inj_x    [2];
  logic [6:0] inj_y    [2];

  int writes, bad, first_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_draw(input logic [3:0] nt, input logic [1:0] oc,
                            input logic [7:0] xx, input logic [6:0] yy);
    ifc.note     = nt;
    ifc.octave   = oc;
    ifc.x        = xx;
    ifc.y        = yy;
    ifc.draw_req = 1'b1;
  endtask

  // Walks the 432 label pixels, one per negedge, counting writes and any
  // pixel that differs from the expected label.
  task automatic scan_draw(input logic [7:0] xx, input logic [6:0] yy,
                           input int g0, input int g1, input int g2, input int stop_at,
                           output int nw, output int nbad, output int fbad);
    int k, r, c, g;
    logic [11:0] rb;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic        ewe;
    logic [2:0]  ecol;
    nw = 0; nbad = 0; fbad = -1;
    for (int i = 0; i < 432; i++) begin
      @(negedge clk);
      ifc.draw_req  = 1'b0;
      ifc.clear_req = 1'b0;
      k = i / 144;
      r = (i % 144) / 12;
      c = i % 12;
      g = (k == 0) ? g0 : (k == 1) ? g1 : g2;
      rb   = GROWS[g][r];
      ex   = 8'(int'(xx) + 12 * k + c);
      ey   = 7'(int'(yy) + r);
      ewe  = (int'(ex) < 160) && (int'(ey) < 120);
      ecol = rb[11 - c] ? 3'b100 : 3'b000;
      if (ifc.writeEn === 1'b1) nw++;
      if (ifc.writeEn !== ewe || ifc.x_out !== ex || ifc.y_out !== ey ||
          ifc.colour !== ecol || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
        nbad++;
        if (fbad < 0) fbad = i;
      end
      for (int j = 0; j < 2; j++) begin
        if (inj_at[j] == i) start_draw(inj_note[j], inj_oct[j], inj_x[j], inj_y[j]);
      end
      if (i == stop_at) break;
    end
  endtask

  // FINISH cycle, then (if nothing queued) back to idle
  task automatic check_finish(input string tag, input bit pending);
    @(negedge clk);
    chk({tag, ".done"}, 32'(ifc.done), 32'd1);
    chk({tag, ".busy_fin"}, 32'(ifc.busy), 32'd1);
    chk({tag, ".we_fin"}, 32'(ifc.writeEn), 32'd0);
    if (!pending) begin
      @(negedge clk);
      chk({tag, ".done_drop"}, 32'(ifc.done), 32'd0);
      chk({tag, ".busy_drop"}, 32'(ifc.busy), 32'd0);
    end
  endtask

  initial begin
    int cbad, cw, ibad;
    for (int j = 0; j < 2; j++) begin
      inj_at[j] = -1; inj_note[j] = '0; inj_oct[j] = '0; inj_x[j] = '0; inj_y[j] = '0;
    end
    ifc.draw_req = 1'b0; ifc.clear_req = 1'b0;
    ifc.note = '0; ifc.octave = '0; ifc.x = '0; ifc.y = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.x_out", 32'(ifc.x_out), 32'd0);
    chk("rst.y_out", 32'(ifc.y_out), 32'd0);
    chk("rst.colour", 32'(ifc.colour), 32'd0);
    chk("rst.writeEn", 32'(ifc.writeEn), 32'd0);
    chk("rst.busy", 32'(ifc.busy), 32'd0);
    chk("rst.done", 32'(ifc.done), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // C#, octave 2 at (10,20): sharp, C, digit 3
    start_draw(4'd5, 2'd2, 8'd10, 7'd20);
    scan_draw(8'd10, 7'd20, 1, 4, 11, -1, writes, bad, first_bad);
    $display("draw C#2 @(10,20): writes=%0d pixel_diffs=%0d", writes, bad);
    chk("csharp.pixels", 32'(bad), 32'd0);
    chk("csharp.writes", 32'(writes), 32'd432);
    check_finish("csharp", 1'b0);

    // A, octave 0: sharp cells written as background
    @(negedge clk);
    start_draw(4'd1, 2'd0, 8'd40, 7'd50);
    scan_draw(8'd40, 7'd50, 0, 2, 9, -1, writes, bad, first_bad);
    $display("draw A0 @(40,50): writes=%0d pixel_diffs=%0d", writes, bad);
    chk("a0.pixels", 32'(bad), 32'd0);
    chk("a0.writes", 32'(writes), 32'd432);
    check_finish("a0", 1'b0);

    // E, octave 3 at (150,115): only 10x5 sharp-cell pixels on screen
    start_draw(4'd8, 2'd3, 8'd150, 7'd115);
    scan_draw(8'd150, 7'd115, 0, 6, 12, -1, writes, bad, first_bad);
    $display("draw E3 @(150,115): writes=%0d pixel_diffs=%0d", writes, bad);
    chk("clip.pixels", 32'(bad), 32'd0);
    chk("clip.writes", 32'(writes), 32'd50);
    check_finish("clip", 1'b0);

`ifdef NOTE_DRAW_CLEAR_EN
    // Clear and draw together: clear sweep first, then the queued draw
    @(negedge clk);
    ifc.clear_req = 1'b1;
    start_draw(4'd11, 2'd1, 8'd0, 7'd0);
    cbad = 0; cw = 0;
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      ifc.draw_req = 1'b0; ifc.clear_req = 1'b0;
      if (ifc.writeEn === 1'b1) cw++;
      if (ifc.writeEn !== 1'b1 || ifc.x_out !== 8'(i % 160) || ifc.y_out !== 7'(i / 160) ||
          ifc.colour !== 3'b000 || ifc.busy !== 1'b1 || ifc.done !== 1'b0) cbad++;
    end
    $display("clear sweep: writes=%0d pixel_diffs=%0d", cw, cbad);
    chk("clear.pixels", 32'(cbad), 32'd0);
    chk("clear.writes", 32'(cw), 32'd19200);
    check_finish("clear", 1'b1);
    scan_draw(8'd0, 7'd0, 0, 8, 10, -1, writes, bad, first_bad);
`else
    // clear_req alone is ignored; with draw_req the draw starts at once
    @(negedge clk);
    ifc.clear_req = 1'b1;
    @(negedge clk);
    ifc.clear_req = 1'b0;
    chk("noclear.busy", 32'(ifc.busy), 32'd0);
    chk("noclear.we", 32'(ifc.writeEn), 32'd0);
    ifc.clear_req = 1'b1;
    start_draw(4'd11, 2'd1, 8'd0, 7'd0);
    scan_draw(8'd0, 7'd0, 0, 8, 10, -1, writes, bad, first_bad);
`endif
    $display("draw G1 @(0,0): writes=%0d pixel_diffs=%0d", writes, bad);
    chk("g1.pixels", 32'(bad), 32'd0);
    chk("g1.writes", 32'(writes), 32'd432);
    check_finish("g1", 1'b0);

    // Two requests during a draw: only the later one runs afterwards
    inj_at[0] = 100; inj_note[0] = 4'd6;  inj_oct[0] = 2'd3; inj_x[0] = 8'd20; inj_y[0] = 7'd5;
    inj_at[1] = 300; inj_note[1] = 4'd12; inj_oct[1] = 2'd0; inj_x[1] = 8'd90; inj_y[1] = 7'd40;
    start_draw(4'd3, 2'd1, 8'd60, 7'd60);
    scan_draw(8'd60, 7'd60, 0, 3, 10, -1, writes, bad, first_bad);
    inj_at[0] = -1; inj_at[1] = -1;
    $display("draw B1 @(60,60) with 2 queued: writes=%0d pixel_diffs=%0d", writes, bad);
    chk("b1.pixels", 32'(bad), 32'd0);
    check_finish("b1", 1'b1);
    scan_draw(8'd90, 7'd40, 1, 8, 9, -1, writes, bad, first_bad);
    $display("queued G#0 @(90,40): writes=%0d pixel_diffs=%0d", writes, bad);
    chk("gs0.pixels", 32'(bad), 32'd0);
    chk("gs0.writes", 32'(writes), 32'd432);
    check_finish("gs0", 1'b0);
    ibad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifc.writeEn !== 1'b0 || ifc.busy !== 1'b0) ibad++;
    end
    chk("gs0.idle_after", 32'(ibad), 32'd0);

    // Reset asserted at pixel 200, then a normal draw
    start_draw(4'd9, 2'd1, 8'd5, 7'd5);
    scan_draw(8'd5, 7'd5, 0, 7, 10, 200, writes, bad, first_bad);
    $display("draw F1 aborted at pixel 200: pixel_diffs=%0d", bad);
    chk("abort.pixels", 32'(bad), 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("abort.writeEn", 32'(ifc.writeEn), 32'd0);
    chk("abort.busy", 32'(ifc.busy), 32'd0);
    chk("abort.x_out", 32'(ifc.x_out), 32'd0);
    chk("abort.y_out", 32'(ifc.y_out), 32'd0);
    chk("abort.colour", 32'(ifc.colour), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort.idle", 32'(ifc.busy), 32'd0);
    start_draw(4'd10, 2'd3, 8'd100, 7'd100);
    scan_draw(8'd100, 7'd100, 1, 7, 12, -1, writes, bad, first_bad);
    $display("draw F#3 @(100,100) after reset: writes=%0d pixel_diffs=%0d", writes, bad);
    chk("fs3.pixels", 32'(bad), 32'd0);
    chk("fs3.writes", 32'(writes), 32'd432);
    check_finish("fs3", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
